// File: rtl/qu_common_pkg.sv
// +--------------------------------------------------------------------+
// | qu_common : shared data-memory depth, request struct, index helper |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package qu_common;

  localparam int MEM_DEPTH = 1024;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);

  typedef struct packed {
    logic [3:0]  wr_en;
    logic        rd_en;
    logic [31:0] addr;
    logic [31:0] data;
  } dmem_req_t;

  // Byte address to word index; upper bits are dropped so addresses wrap.
  function automatic logic [MEM_AW-1:0] word_index(input logic [31:0] addr);
    return addr[MEM_AW+1:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_resp_pipe.sv
// +--------------------------------------------------------------------+
// | dmem_resp_pipe : DEPTH-stage valid/addr/data shift, registered out |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_resp_pipe #(
  parameter int DEPTH = 2,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  output logic          last_valid,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];

  // The last stage is what the output register consumes on the next edge.
  assign last_valid = r_valid[DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
      end
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else begin
      r_valid[0] <= req_valid;
      r_addr[0]  <= req_addr;
      r_data[0]  <= req_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
        r_data[i]  <= r_data[i-1];
      end
      valid <= r_valid[DEPTH-1];
      if (r_valid[DEPTH-1]) begin
        addr <= r_addr[DEPTH-1];
        data <= r_data[DEPTH-1];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +--------------------------------------------------------------------+
// | dmem_responder : byte-writable data memory with fixed read latency |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_responder
    import qu_common::*;
#(
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        dmem_wr_en_in,
    input  logic              dmem_rd_en_in,
    input  logic [31:0]       dmem_addr_in,
    input  logic [31:0]       dmem_data_in,
    output logic              dmem_valid_out,
    output logic [MEM_AW-1:0] dmem_valid_addr_out,
    output logic [31:0]       dmem_data_out,
    output logic [3:0]        dmem_inflight_out
);

    dmem_req_t         w_req;
    logic [MEM_AW-1:0] w_idx;
    logic [31:0]       w_merged;
    logic              w_ret;
    logic [31:0]       r_mem [MEM_DEPTH];

    assign w_req = '{wr_en: dmem_wr_en_in, rd_en: dmem_rd_en_in,
                     addr: dmem_addr_in, data: dmem_data_in};
    assign w_idx = word_index(w_req.addr);

    // Write-first view of the addressed word for a same-cycle read.
    always_comb begin
        w_merged = r_mem[w_idx];
        for (int b = 0; b < 4; b++) begin
            if (w_req.wr_en[b]) w_merged[8*b +: 8] = w_req.data[8*b +: 8];
        end
    end

    // Array has no reset; stores are simply blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < 4; b++) begin
                if (w_req.wr_en[b]) r_mem[w_idx][8*b +: 8] <= w_req.data[8*b +: 8];
            end
        end
    end

    dmem_resp_pipe #(
        .DEPTH (LATENCY),
        .AW    (MEM_AW),
        .DW    (32)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (w_req.rd_en),
        .req_addr   (w_idx),
        .req_data   (w_merged),
        .last_valid (w_ret),
        .valid      (dmem_valid_out),
        .addr       (dmem_valid_addr_out),
        .data       (dmem_data_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_inflight_out <= 4'd0;
        end else if (w_req.rd_en && !w_ret) begin
            dmem_inflight_out <= dmem_inflight_out + 4'd1;
        end else if (!w_req.rd_en && w_ret) begin
            dmem_inflight_out <= dmem_inflight_out - 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +--------------------------------------------------------------------+
// | tb_dmem_responder : scoreboard bench, LATENCY 1 / 2 / 8 instances  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  wr_en = 4'd0;
  logic        rd_en = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] data = 32'd0;

  logic        v1, v2, v8;
  logic [9:0]  a1, a2, a8;
  logic [31:0] d1, d2, d8;
  logic [3:0]  f1, f2, f8;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int peak2   = 0;

  typedef struct {
    logic [9:0]  idx;
    logic [31:0] word;
    int          acc;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  exp_t        q8[$];
  logic [31:0] model [1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .dmem_wr_en_in(wr_en), .dmem_rd_en_in(rd_en),
    .dmem_addr_in(addr), .dmem_data_in(data), .dmem_valid_out(v1),
    .dmem_valid_addr_out(a1), .dmem_data_out(d1), .dmem_inflight_out(f1));
  dmem_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .dmem_wr_en_in(wr_en), .dmem_rd_en_in(rd_en),
    .dmem_addr_in(addr), .dmem_data_in(data), .dmem_valid_out(v2),
    .dmem_valid_addr_out(a2), .dmem_data_out(d2), .dmem_inflight_out(f2));
  dmem_responder #(.LATENCY(8)) u_l8 (
    .clk(clk), .rst(rst), .dmem_wr_en_in(wr_en), .dmem_rd_en_in(rd_en),
    .dmem_addr_in(addr), .dmem_data_in(data), .dmem_valid_out(v8),
    .dmem_valid_addr_out(a8), .dmem_data_out(d8), .dmem_inflight_out(f8));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Apply one request for one edge and record what the memory must return.
  task automatic step(input logic [3:0] we, input logic re,
                      input logic [31:0] a, input logic [31:0] d);
    logic [9:0]  idx;
    logic [31:0] w;
    exp_t        e;
    wr_en = we; rd_en = re; addr = a; data = d;
    @(posedge clk); #1;
    if (!rst) begin
      idx = a[11:2];
      w = model[idx];
      for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = d[8*b +: 8];
      model[idx] = w;
      if (re) begin
        e.idx = idx; e.word = w; e.acc = cyc;
        q1.push_back(e); q2.push_back(e); q8.push_back(e);
      end
    end
    wr_en = 4'd0; rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 1'b0, 32'd0, 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (v1) begin
        if (q1.size() == 0) check("l1_spurious_valid", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("l1_addr", 32'(a1), 32'(e.idx));
          check("l1_data", d1, e.word);
          check("l1_latency", cyc - e.acc, 32'd1);
        end
      end
      check("l1_inflight", 32'(f1), q1.size());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (v2) begin
        if (q2.size() == 0) check("l2_spurious_valid", 32'd1, 32'd0);
        else begin
          e = q2.pop_front();
          check("l2_addr", 32'(a2), 32'(e.idx));
          check("l2_data", d2, e.word);
          check("l2_latency", cyc - e.acc, 32'd2);
        end
      end
      check("l2_inflight", 32'(f2), q2.size());
      if (int'(f2) > peak2) peak2 = int'(f2);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (v8) begin
        if (q8.size() == 0) check("l8_spurious_valid", 32'd1, 32'd0);
        else begin
          e = q8.pop_front();
          check("l8_addr", 32'(a8), 32'(e.idx));
          check("l8_data", d8, e.word);
          check("l8_latency", cyc - e.acc, 32'd8);
        end
      end
      check("l8_inflight", 32'(f8), q8.size());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(v2), 32'd0);
    check("reset_addr", 32'(a2), 32'd0);
    check("reset_data", d2, 32'd0);
    check("reset_inflight", 32'(f8), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full store then read, then a single-lane update.
    step(4'hF, 1'b0, 32'h10, 32'hDEADBEEF);
    step(4'h0, 1'b1, 32'h10, 32'h0);
    idle(10);
    step(4'b0010, 1'b0, 32'h10, 32'h00005500);
    step(4'h0, 1'b1, 32'h10, 32'h0);
    idle(10);
    check("byte_lane_model", model[4], 32'hDEAD55EF);

    // Back-to-back reads of three words.
    step(4'hF, 1'b0, 32'h0, 32'h11111111);
    step(4'hF, 1'b0, 32'h4, 32'h22222222);
    step(4'hF, 1'b0, 32'h8, 32'h33333333);
    idle(10);
    peak2 = 0;
    step(4'h0, 1'b1, 32'h0, 32'h0);
    step(4'h0, 1'b1, 32'h4, 32'h0);
    step(4'h0, 1'b1, 32'h8, 32'h0);
    idle(10);
    check("l2_inflight_peak", 32'(peak2), 32'd2);

    // Same-cycle store and read is write-first.
    step(4'hF, 1'b1, 32'h20, 32'h12345678);
    idle(10);

    // Random mix over 16 words with scrambled upper and byte-offset bits.
    for (int i = 0; i < 16; i++) step(4'hF, 1'b0, 32'(i) << 2, $urandom);
    for (int i = 0; i < 60; i++) begin
      ra = ($urandom & ~32'h0000_0FFC) | (32'($urandom_range(0, 15)) << 2);
      step(4'($urandom_range(0, 15)) & {4{$urandom_range(0, 1) == 1}},
           $urandom_range(0, 2) != 0, ra, $urandom);
    end
    idle(12);

    // Reset one cycle after a read: the read is discarded, array retained.
    step(4'h0, 1'b1, 32'h20, 32'h0);
    rst = 1'b1;
    wr_en = 4'hF; addr = 32'h20; data = 32'h0BAD0BAD;
    q1.delete(); q2.delete(); q8.delete();
    @(negedge clk);
    check("midrst_valid", 32'(v1), 32'd0);
    check("midrst_inflight", 32'(f8), 32'd0);
    check("midrst_data", d2, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 4'd0;
    idle(12);
    check("post_rst_inflight_l2", 32'(f2), 32'd0);
    check("post_rst_inflight_l8", 32'(f8), 32'd0);
    step(4'h0, 1'b1, 32'h20, 32'h0);
    idle(12);

    check("drain_l1", q1.size(), 32'd0);
    check("drain_l2", q2.size(), 32'd0);
    check("drain_l8", q8.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
